// File: rtl/uart_rx_frame_checker_if.sv
// Receiver-byte / FIFO-write / status bundle for uart_rx_frame_checker.
// The master drives the receiver bytes and the FIFO full flag; the slave is the checker.
interface uart_rx_frame_checker_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic [7:0]       din;
    logic             din_valid;
    logic             fifo_full;
    logic [7:0]       fifo_dout;
    logic             fifo_wr_en;
    logic             pkt_ok;
    logic             pkt_err;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output din, din_valid, fifo_full,
        input  fifo_dout, fifo_wr_en, pkt_ok, pkt_err, ok_cnt, err_cnt, drop_cnt
    );

    modport slave (
        input  din, din_valid, fifo_full,
        output fifo_dout, fifo_wr_en, pkt_ok, pkt_err, ok_cnt, err_cnt, drop_cnt
    );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// Sync-hunting frame checker: buffers a payload, verifies its XOR checksum, then drains it to a FIFO.
// Define UART_RX_FRAME_LEN_PASS_EN to forward the LEN byte ahead of the payload.
module uart_rx_frame_checker #(
    parameter int unsigned MAX_PAYLOAD    = 64,
    parameter logic [7:0]  SYNC0          = 8'hAA,
    parameter logic [7:0]  SYNC1          = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input logic                   clk,
    input logic                   rst,
    uart_rx_frame_checker_if.slave bus
);
    localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {StHunt0, StHunt1, StLen, StPayload, StCsum, StDrain} state_e;

    state_e           state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       wr_idx_q, wr_idx_d;
    logic [7:0]       rd_idx_q, rd_idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             drop_inc;
    logic [CNT_W-1:0] ok_cnt_q, err_cnt_q, drop_cnt_q;
    logic             mem_we;
    logic [7:0]       mem_q [MAX_PAYLOAD];
    logic             wr_en;
    logic [7:0]       rd_ptr;
    logic [7:0]       rd_data;
    logic [7:0]       last_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign wr_en = (state_q == StDrain) && !bus.fifo_full;

`ifdef UART_RX_FRAME_LEN_PASS_EN
    // Slot 0 of the drain carries LEN; payload byte k sits in slot k+1.
    assign rd_ptr   = rd_idx_q - 8'd1;
    assign rd_data  = (rd_idx_q == 8'd0) ? len_q : mem_q[rd_ptr[AW-1:0]];
    assign last_idx = len_q;
`else
    assign rd_ptr   = rd_idx_q;
    assign rd_data  = mem_q[rd_ptr[AW-1:0]];
    assign last_idx = len_q - 8'd1;
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        csum_d   = csum_q;
        timer_d  = '0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        drop_inc = 1'b0;
        mem_we   = 1'b0;

        if (state_q inside {StHunt1, StLen, StPayload, StCsum} && !bus.din_valid) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = StHunt0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        unique case (state_q)
            StHunt0: begin
                if (bus.din_valid && bus.din == SYNC0) state_d = StHunt1;
            end
            StHunt1: begin
                if (bus.din_valid) begin
                    if (bus.din == SYNC1)      state_d = StLen;
                    else if (bus.din != SYNC0) state_d = StHunt0;
                end
            end
            StLen: begin
                if (bus.din_valid) begin
                    if (bus.din == 8'd0 || 32'(bus.din) > MAX_PAYLOAD) begin
                        err_d   = 1'b1;
                        state_d = StHunt0;
                    end else begin
                        len_d    = bus.din;
                        csum_d   = bus.din;
                        wr_idx_d = 8'd0;
                        state_d  = StPayload;
                    end
                end
            end
            StPayload: begin
                if (bus.din_valid) begin
                    mem_we   = 1'b1;
                    csum_d   = csum_q ^ bus.din;
                    wr_idx_d = wr_idx_q + 8'd1;
                    if (wr_idx_q == len_q - 8'd1) state_d = StCsum;
                end
            end
            StCsum: begin
                if (bus.din_valid) begin
                    if (bus.din == csum_q) begin
                        rd_idx_d = 8'd0;
                        state_d  = StDrain;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StHunt0;
                    end
                end
            end
            StDrain: begin
                drop_inc = bus.din_valid;
                if (wr_en) begin
                    rd_idx_d = rd_idx_q + 8'd1;
                    if (rd_idx_q == last_idx) begin
                        ok_d    = 1'b1;
                        state_d = StHunt0;
                    end
                end
            end
            default: state_d = StHunt0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StHunt0;
            len_q      <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            csum_q     <= '0;
            timer_q    <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            csum_q     <= csum_d;
            timer_q    <= timer_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            ok_cnt_q   <= sat_inc(ok_cnt_q, ok_d);
            err_cnt_q  <= sat_inc(err_cnt_q, err_d);
            drop_cnt_q <= sat_inc(drop_cnt_q, drop_inc);
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_idx_q[AW-1:0]] <= bus.din;
    end

    assign bus.fifo_wr_en = wr_en;
    assign bus.fifo_dout  = (state_q == StDrain) ? rd_data : 8'h00;
    assign bus.pkt_ok     = ok_q;
    assign bus.pkt_err    = err_q;
    assign bus.ok_cnt     = ok_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
- Sits between the UART receiver and the input FIFO; consumes the receiver's byte stream (dout/we).
- Hunts for a two-byte sync header and length byte, buffers the payload, and verifies an XOR checksum.
- Forwards only verified payload bytes to the input FIFO write port, so the parsing stage never sees corrupted or partial packets.

Parameters:
- MAX_PAYLOAD, 64: maximum payload bytes per frame and buffer depth.
- SYNC0, 8'hAA: first sync byte.
- SYNC1, 8'h55: second sync byte.
- TIMEOUT_CYCLES, 50000: idle clock cycles between bytes, mid-frame, before the frame is abandoned.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- din  in  8  byte from the receiver.
- din_valid  in  1  one-cycle strobe; din is valid this cycle.
- fifo_full  in  1  input-FIFO full flag.
- fifo_dout  out  8  byte to the FIFO.
- fifo_wr_en  out  1  FIFO write strobe.
- pkt_ok  out  1  one-cycle pulse when a verified frame has finished draining.
- pkt_err  out  1  one-cycle pulse on any checksum, length or timeout error.
- ok_cnt  out  CNT_W  verified frames, saturating.
- err_cnt  out  CNT_W  errored frames, saturating.
- drop_cnt  out  CNT_W  bytes dropped while in DRAIN, saturating.

Behaviour:
- Reset (rst low, asynchronous): state=HUNT0; all indices and the idle timer clear; fifo_wr_en=0, fifo_dout=0, pkt_ok=0, pkt_err=0; all counters 0. The buffer contents are not reset.
- Frame format: SYNC0, SYNC1, LEN (1..MAX_PAYLOAD), LEN payload bytes, CSUM. CSUM = LEN ^ payload[0] ^ ... ^ payload[LEN-1].
- All state changes below happen on a din_valid cycle unless stated otherwise.
- HUNT0: din==SYNC0 -> HUNT1; otherwise stay.
- HUNT1: din==SYNC1 -> LEN; din==SYNC0 -> stay in HUNT1; otherwise -> HUNT0. No error is flagged.
- LEN:
  - din==0 or din>MAX_PAYLOAD -> pkt_err pulse, err_cnt+1, -> HUNT0.
  - Otherwise latch len, set csum=din, wr_idx=0, -> PAYLOAD.
- PAYLOAD: write buf[wr_idx]=din; csum^=din; wr_idx+1. After the len-th byte -> CSUM.
- CSUM:
  - din==csum -> DRAIN with rd_idx=0.
  - Mismatch -> pkt_err pulse, err_cnt+1, -> HUNT0.
- Timeout: in HUNT1, LEN, PAYLOAD and CSUM, the idle timer increments every cycle without din_valid and clears on din_valid.
  - When it reaches TIMEOUT_CYCLES -> pkt_err pulse, err_cnt+1, -> HUNT0.
  - The timer is held at 0 in HUNT0 and DRAIN.
- DRAIN:
  - fifo_wr_en = (state==DRAIN) && !fifo_full, combinational from registered state.
  - fifo_dout = buf[rd_idx]; rd_idx advances on each cycle where fifo_wr_en=1.
  - When fifo_full=1, fifo_wr_en=0 and rd_idx holds; no data is lost.
  - After the len-th write -> HUNT0, with a pkt_ok pulse and ok_cnt+1 in the following cycle.
- Latency: the first fifo_wr_en occurs in the cycle after the CSUM byte's din_valid. A frame of N bytes drains in N cycles when the FIFO is never full.
- Any din_valid while in DRAIN: the byte is discarded and drop_cnt+1. The hunter restarts in HUNT0 after the drain; a frame whose sync arrived during DRAIN is lost.
- Counters saturate at 2^CNT_W-1.
- pkt_ok and pkt_err are never asserted in the same cycle.
- Reset mid-operation: an asynchronous abort from any state. Partially drained bytes already in the FIFO remain; the FIFO's own srst clears them.

Optional Feature:
- UART_RX_FRAME_LEN_PASS_EN defined: DRAIN first writes the LEN byte and then the payload, for len+1 writes total.
- Undefined: only the payload bytes are written.
- Checksum and error rules are identical in both builds.

Test Plan:
- Good frame AA 55 03 01 02 03 03, FIFO never full: 3 writes 01,02,03 on consecutive cycles starting the cycle after the CSUM strobe; pkt_ok=1 once; ok_cnt=1. With the macro defined: 4 writes 03,01,02,03.
- Same frame with CSUM 04: no fifo_wr_en; pkt_err=1 once; err_cnt=1. A following good frame is accepted.
- Resync stream 12 AA AA 55 01 7F 7E: exactly 1 write of 7F; err_cnt=0.
- LEN=00, and separately LEN=MAX_PAYLOAD+1: pkt_err each time; err_cnt=2; no writes.
- Backpressure: good 3-byte frame with fifo_full held high for 10 cycles after the first write: writes 01, stall, then 02, 03; order preserved; no duplicates.
- Timeout and reset:
  - AA 55 02 11, then TIMEOUT_CYCLES idle cycles -> pkt_err and HUNT0; a subsequent good frame passes.
  - A byte injected during DRAIN -> drop_cnt=1.
  - rst low mid-DRAIN -> fifo_wr_en=0 immediately; all counters 0.
